// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, single-outstanding imem requester, {inst, pc+4} FIFO.
// Rev 1.0
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_plus4_o
);

  localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_C = (AW + 1)'(DEPTH);

  // Bit 0 of the encoding is the request line, so imem_req_o comes straight off a flop.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b11
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, req_addr;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc4_mem  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_after;
  logic        ack, pop, push, issue, can_issue;
  logic [31:0] redirect_target;
  logic        unused_pc_bits;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    ack         = imem_ack_i && (state != IDLE);
    pop         = (count != '0) && !stall_i && !redirect_i;
    push        = (state == BUSY) && ack && !redirect_i;
    count_after = count - {{AW{1'b0}}, pop} + {{AW{1'b0}}, push};
    // A slot must be free after this edge's pop/push before a new request goes out.
    can_issue   = start_i && !redirect_i && (count_after < DEPTH_C);
    case (state)
      IDLE: begin
        if (can_issue) begin
          issue      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (redirect_i) begin
          state_next = ack ? IDLE : DRAIN;
        end else if (ack) begin
          if (can_issue) issue = 1'b1;
          else           state_next = IDLE;
        end
      end
      DRAIN: begin
        // An ack here retires the stale request even if a new redirect arrives with it.
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_data_i;
      pc4_mem[wr_ptr]  <= req_addr + 32'd4;
    end
  end

  assign imem_req_o   = state[0];
  assign imem_addr_o  = req_addr;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : 32'h0;
  assign pc_plus4_o   = inst_valid_o ? pc4_mem[rd_ptr]  : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue with a transaction-level model.
`default_nettype none

module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_plus4_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .pc_plus4_o(pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  entry_t      sb_q[$];
  entry_t      head;
  int          checks = 0;
  int          fails  = 0;

  // Model: what the fetch unit should be doing, tracked as transactions.
  bit          m_busy, m_drain;
  logic [31:0] m_pc, m_addr;
  int          wait_left;
  bit          armed;
  bit          e_req, e_valid;
  logic [31:0] e_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples between driver update and the next rising edge.
  always @(negedge clk) begin
    #1;
    if (armed) begin
      check("req", {31'b0, imem_req_o}, {31'b0, e_req});
      check("addr", imem_addr_o, e_addr);
      check("valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
      if (!inst_valid_o) begin
        check("inst_empty", inst_o, 32'h0);
        check("pc4_empty", pc_plus4_o, 32'h0);
      end else if (!redirect_i) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          head = sb_q[0];
          check("inst", inst_o, head.inst);
          check("pc_plus4", pc_plus4_o, head.pc4);
          if (!stall_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    m_busy = 0; m_drain = 0;
    m_pc = RESET_PC; m_addr = RESET_PC;
    wait_left = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    armed = 0;
    #2 rst_i = 1'b0;
    start_i = 0; imem_ack_i = 0; redirect_i = 0; stall_i = 0;
    #1;
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic run(input int n, input int p_stall, input int p_redir_pm,
                     input int max_wait, input int p_start);
    bit ack_eff, was_idle, was_busy;
    int pop, push, size;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e_req   = m_busy || m_drain;
      e_addr  = m_addr;
      e_valid = (sb_q.size() != 0);

      stall_i    = ($urandom_range(99) < p_stall);
      start_i    = ($urandom_range(99) < p_start);
      redirect_i = ($urandom_range(999) < p_redir_pm);
      redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : (32'h100 + 32'($urandom_range(255)));
      if (e_req) begin
        imem_ack_i = (wait_left == 0);
        if (wait_left > 0) wait_left--;
      end else begin
        imem_ack_i = ($urandom_range(99) < 5);
      end
      imem_data_i = mem_word(imem_addr_o);

      size     = sb_q.size();
      ack_eff  = imem_ack_i && e_req;
      was_idle = !m_busy && !m_drain;
      was_busy = m_busy;
      pop      = (size > 0 && !stall_i && !redirect_i) ? 1 : 0;
      push     = (m_busy && ack_eff && !redirect_i) ? 1 : 0;
      if (redirect_i) begin
        sb_q.delete();
        m_pc = {redirect_pc_i[31:2], 2'b00};
        if (ack_eff) begin
          m_busy = 0; m_drain = 0;
        end else if (m_busy) begin
          m_busy = 0; m_drain = 1;
        end
      end else begin
        if (push == 1) sb_q.push_back('{inst: mem_word(m_addr), pc4: m_addr + 32'd4});
        if (ack_eff) begin
          m_busy = 0; m_drain = 0;
        end
        if ((was_idle || (was_busy && ack_eff)) && start_i && (size - pop + push < DEPTH)) begin
          m_busy = 1;
          m_addr = m_pc;
          m_pc   = m_pc + 32'd4;
          wait_left = $urandom_range(max_wait);
        end
      end
      armed = 1;
    end
  endtask

  initial begin
    armed = 0;
    rst_i = 1'b0;
    start_i = 0; imem_ack_i = 0; imem_data_i = 0;
    redirect_i = 0; redirect_pc_i = 0; stall_i = 0;
    model_reset();
    #12;
    do_reset();
    run(40, 0, 0, 0, 100);      // back-to-back fetch, wraps past 0xFFFF_FFFC
    run(12, 100, 0, 0, 100);    // stall until full
    run(20, 0, 0, 0, 100);      // drain and resume
    run(1500, 30, 40, 3, 85);   // mixed stalls, waits, redirects
    do_reset();                 // asynchronous reset mid-traffic
    run(400, 30, 40, 3, 85);
    @(negedge clk);
    armed = 0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
